// File: rtl/rob_prof_pkg.sv
// rob_prof_pkg: shared types for the ROB phase profiler.
// Marker decode, phase/state enums and the default event layout.
package rob_prof_pkg;

  localparam logic [19:0] MARKER_LO = 20'h02013;

  typedef enum logic [3:0] {
    PH_VCTM,
    PH_DELAY,
    PH_TEXE,
    PH_LEAK,
    PH_INIT,
    PH_BIM,
    PH_TRAIN
  } phase_e;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } ph_state_e;

  typedef struct packed {
    logic [31:0] ts;
    logic [3:0]  phase;
    logic        is_end;
    logic        err;
    logic [2:0]  lane;
    logic [23:0] cycles;
    logic [15:0] taint_peak;
  } rob_evt_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] phase;
    logic       is_end;
  } marker_t;

  // slti x0, x0, imm with imm below lim is a marker
  function automatic marker_t decode_marker(
    input logic [31:0] inst,
    input logic [11:0] lim
  );
    marker_t m;
    m.hit    = (inst[19:0] == MARKER_LO) && (inst[31:20] < lim);
    m.phase  = inst[24:21];
    m.is_end = inst[20];
    return m;
  endfunction

endpackage

// File: rtl/rob_evt_fifo.sv
// rob_evt_fifo: multi-push, single-pop event FIFO.
// Pushes beyond free space are dropped, lowest lanes win.
module rob_evt_fifo #(
  parameter int W     = 81,
  parameter int DEPTH = 16,
  parameter int NPUSH = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NPUSH-1:0]          push_valid,
  input  logic [NPUSH-1:0][W-1:0]   push_data,
  input  logic                      pop_ready,
  output logic                      head_valid,
  output logic [W-1:0]              head_data,
  output logic [15:0]               drop_count,
  output logic                      overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]               mem [DEPTH];
  logic [AW-1:0]              rd_q;
  logic [AW-1:0]              wr_q;
  logic [AW:0]                cnt_q;
  logic [AW:0]                free;
  logic [AW:0]                n_acc;
  logic [AW:0]                n_drop;
  logic [NPUSH-1:0]           acc;
  logic [NPUSH-1:0][AW-1:0]   waddr;
  logic [16:0]                dsum;
  logic                       pop;

  assign head_valid = cnt_q != '0;
  assign pop        = head_valid & pop_ready;
  assign head_data  = head_valid ? mem[rd_q] : '0;

  always_comb begin
    free   = (AW+1)'(DEPTH) - cnt_q + {{AW{1'b0}}, pop};
    n_acc  = '0;
    n_drop = '0;
    acc    = '0;
    waddr  = '0;
    for (int i = 0; i < NPUSH; i++) begin
      if (push_valid[i]) begin
        if (n_acc < free) begin
          acc[i]   = 1'b1;
          waddr[i] = wr_q + n_acc[AW-1:0];
          n_acc    = n_acc + 1'b1;
        end else begin
          n_drop = n_drop + 1'b1;
        end
      end
    end
    dsum = {1'b0, drop_count} + 17'(n_drop);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      rd_q       <= rd_q + AW'(pop);
      wr_q       <= wr_q + n_acc[AW-1:0];
      cnt_q      <= cnt_q - {{AW{1'b0}}, pop} + n_acc;
      drop_count <= dsum[16] ? 16'hFFFF : dsum[15:0];
      if (n_drop != '0) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NPUSH; i++) begin
      if (acc[i]) mem[waddr[i]] <= push_data[i];
    end
  end

endmodule

// File: rtl/rob_phase_profiler.sv
// rob_phase_profiler: decodes commit-lane phase markers,
// times each phase and queues timestamped event records.
module rob_phase_profiler
  import rob_prof_pkg::*;
#(
  parameter int COMMIT_WIDTH = 2,
  parameter int NUM_PHASES   = 7,
  parameter int TS_W         = 32,
  parameter int CNT_W        = 24,
  parameter int TAINT_W      = 16,
  parameter int FIFO_DEPTH   = 16,
  localparam int EVT_W = TS_W + 9 + CNT_W + TAINT_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [COMMIT_WIDTH-1:0]    commit_valid,
  input  logic [COMMIT_WIDTH*32-1:0] commit_inst,
  input  logic [TAINT_W-1:0]         taint_sum,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [EVT_W-1:0]           evt_data,
  output logic [NUM_PHASES-1:0]      phase_active,
  output logic [15:0]                drop_count,
  output logic                       overflow
);

  localparam logic [11:0] IMM_LIM = 12'(2 * NUM_PHASES);

  ph_state_e          st_q  [NUM_PHASES];
  ph_state_e          st_d  [NUM_PHASES];
  logic [CNT_W-1:0]   cnt_q [NUM_PHASES];
  logic [CNT_W-1:0]   cnt_d [NUM_PHASES];
  logic [TAINT_W-1:0] pk_q  [NUM_PHASES];
  logic [TAINT_W-1:0] pk_d  [NUM_PHASES];
  logic [TS_W-1:0]    ts_q;

  logic [COMMIT_WIDTH-1:0]            rec_v;
  logic [COMMIT_WIDTH-1:0][EVT_W-1:0] rec_d;
  marker_t                            mk;
  logic                               rec_err;
  logic [CNT_W-1:0]                   rec_cyc;
  logic [TAINT_W-1:0]                 rec_pk;

  // Lanes resolve oldest first so same-cycle markers chain
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    pk_d    = pk_q;
    rec_v   = '0;
    rec_d   = '0;
    mk      = '0;
    rec_err = 1'b0;
    rec_cyc = '0;
    rec_pk  = '0;
    for (int l = 0; l < COMMIT_WIDTH; l++) begin
      mk = decode_marker(commit_inst[l*32 +: 32], IMM_LIM);
      for (int q = 0; q < NUM_PHASES; q++) begin
        if (commit_valid[l] && mk.hit && mk.phase == 4'(q)) begin
          rec_v[l] = 1'b1;
          if (!mk.is_end) begin
            rec_err  = st_d[q] == ST_ACTIVE;
            rec_cyc  = '0;
            rec_pk   = taint_sum;
            st_d[q]  = ST_ACTIVE;
            cnt_d[q] = '0;
            pk_d[q]  = taint_sum;
          end else if (st_d[q] == ST_ACTIVE) begin
            rec_err = 1'b0;
            rec_cyc = cnt_d[q];
            rec_pk  = (taint_sum > pk_d[q]) ? taint_sum : pk_d[q];
            st_d[q] = ST_IDLE;
          end else begin
            rec_err = 1'b1;
            rec_cyc = '0;
            rec_pk  = '0;
          end
          rec_d[l] = {ts_q, mk.phase, mk.is_end, rec_err,
                      3'(l), rec_cyc, rec_pk};
        end
      end
    end
    for (int q = 0; q < NUM_PHASES; q++) begin
      if (st_d[q] == ST_ACTIVE) begin
        if (!(&cnt_d[q])) cnt_d[q] = cnt_d[q] + 1'b1;
        if (taint_sum > pk_d[q]) pk_d[q] = taint_sum;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ts_q <= '0;
      for (int q = 0; q < NUM_PHASES; q++) begin
        st_q[q]  <= ST_IDLE;
        cnt_q[q] <= '0;
        pk_q[q]  <= '0;
      end
    end else begin
      ts_q <= ts_q + 1'b1;
      for (int q = 0; q < NUM_PHASES; q++) begin
        st_q[q]  <= st_d[q];
        cnt_q[q] <= cnt_d[q];
        pk_q[q]  <= pk_d[q];
      end
    end
  end

  always_comb begin
    phase_active = '0;
    for (int q = 0; q < NUM_PHASES; q++) begin
      phase_active[q] = st_q[q] == ST_ACTIVE;
    end
  end

  rob_evt_fifo #(
    .W     (EVT_W),
    .DEPTH (FIFO_DEPTH),
    .NPUSH (COMMIT_WIDTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_valid (rec_v),
    .push_data  (rec_d),
    .pop_ready  (evt_ready),
    .head_valid (evt_valid),
    .head_data  (evt_data),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

endmodule

// File: tb/tb_rob_phase_profiler.sv
// tb_rob_phase_profiler: random and directed checks of the
// phase profiler against a timestamp-based reference model.
module tb_rob_phase_profiler;

  localparam int EW    = 8 + 9 + 10 + 16;
  localparam int DEPTH = 16;
  localparam int CMAX  = 1023;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    cv = '0;
  logic [63:0]   ci = '0;
  logic [15:0]   taint = '0;
  logic          rdy = 1'b0;
  logic          evt_valid;
  logic [EW-1:0] evt_data;
  logic [6:0]    phase_active;
  logic [15:0]   drop_count;
  logic          overflow;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // reference model state
  logic [EW-1:0] q[$];
  bit            act [7];
  int            t_start [7];
  logic [15:0]   pk [7];
  int            drops;
  bit            ovf;
  int            cyc;

  rob_phase_profiler #(
    .COMMIT_WIDTH (2),
    .NUM_PHASES   (7),
    .TS_W         (8),
    .CNT_W        (10),
    .TAINT_W      (16),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .commit_valid (cv),
    .commit_inst  (ci),
    .taint_sum    (taint),
    .evt_valid    (evt_valid),
    .evt_ready    (rdy),
    .evt_data     (evt_data),
    .phase_active (phase_active),
    .drop_count   (drop_count),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  function automatic logic [EW-1:0] rec(input int t, input int ph,
    input bit e, input bit er, input int ln, input int cy, input int p);
    return {8'(t), 4'(ph), e, er, 3'(ln), 10'(cy), 16'(p)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, a, e);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int p = 0; p < 7; p++) begin
      act[p] = 1'b0;
      t_start[p] = 0;
      pk[p] = '0;
    end
    drops = 0;
    ovf = 1'b0;
    cyc = 0;
  endtask

  task automatic model_step(input logic [1:0] v, input logic [31:0] i0,
    input logic [31:0] i1, input logic [15:0] t, input bit r);
    logic [31:0]   ins;
    logic [EW-1:0] rc;
    int            ph;
    int            room;
    int            el;
    if (r && q.size() > 0) rc = q.pop_front();
    room = DEPTH - q.size();
    for (int l = 0; l < 2; l++) begin
      ins = (l == 0) ? i0 : i1;
      if (v[l] && ins[19:0] == 20'h02013 && ins[31:20] < 12'd14) begin
        ph = int'(ins[24:21]);
        if (!ins[20]) begin
          rc = rec(cyc, ph, 1'b0, act[ph], l, 0, int'(t));
          act[ph] = 1'b1;
          t_start[ph] = cyc;
          pk[ph] = t;
        end else if (act[ph]) begin
          el = cyc - t_start[ph];
          rc = rec(cyc, ph, 1'b1, 1'b0, l, (el > CMAX) ? CMAX : el,
                   int'((t > pk[ph]) ? t : pk[ph]));
          act[ph] = 1'b0;
        end else begin
          rc = rec(cyc, ph, 1'b1, 1'b1, l, 0, 0);
        end
        if (room > 0) begin
          q.push_back(rc);
          room--;
        end else begin
          if (drops < 65535) drops++;
          ovf = 1'b1;
        end
      end
    end
    for (int p = 0; p < 7; p++) begin
      if (act[p] && t > pk[p]) pk[p] = t;
    end
    cyc++;
  endtask

  task automatic step(input logic [1:0] v, input logic [31:0] i0,
    input logic [31:0] i1, input logic [15:0] t, input bit r);
    cv = v;
    ci = {i1, i0};
    taint = t;
    rdy = r;
    @(posedge clock);
    #1;
    model_step(v, i0, i1, t, r);
    cv = '0;
    ci = '0;
  endtask

  task automatic idle(input int n, input bit r);
    for (int k = 0; k < n; k++) step(2'b00, '0, '0, '0, r);
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      logic [6:0] pa;
      for (int p = 0; p < 7; p++) pa[p] = act[p];
      chk("evt_valid", 64'(evt_valid), 64'(q.size() != 0));
      chk("evt_data", 64'(evt_data), 64'((q.size() != 0) ? q[0] : '0));
      chk("phase_active", 64'(phase_active), 64'(pa));
      chk("drop_count", 64'(drop_count), 64'(drops));
      chk("overflow", 64'(overflow), 64'(ovf));
    end
  end

  function automatic logic [31:0] rnd_inst();
    if ($urandom_range(0, 9) < 8)
      return {12'($urandom_range(0, 15)), 20'h02013};
    return $urandom;
  endfunction

  task automatic zero_checks(input string tag);
    chk({tag, "_valid"}, 64'(evt_valid), 64'd0);
    chk({tag, "_data"}, 64'(evt_data), 64'd0);
    chk({tag, "_active"}, 64'(phase_active), 64'd0);
    chk({tag, "_drops"}, 64'(drop_count), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
  endtask

  initial begin
    model_reset();
    #23;
    zero_checks("reset");
    @(posedge clock);
    #1;
    reset = 1'b1;
    chk_en = 1'b1;

    // one phase, taint 3 -> 9 -> 4
    idle(10, 1'b0);
    step(2'b01, 32'h0000_2013, '0, 16'd3, 1'b0);
    chk("t1_active", 64'(phase_active[0]), 64'd1);
    chk("t1_start", 64'(evt_data), 64'(rec(10, 0, 0, 0, 0, 0, 3)));
    step(2'b00, '0, '0, 16'd9, 1'b0);
    for (int k = 0; k < 3; k++) step(2'b00, '0, '0, 16'd4, 1'b0);
    step(2'b01, 32'h0010_2013, '0, 16'd4, 1'b0);
    chk("t1_idle", 64'(phase_active[0]), 64'd0);
    step(2'b00, '0, '0, '0, 1'b1);
    chk("t1_end", 64'(evt_data), 64'(rec(15, 0, 1, 0, 0, 5, 9)));
    idle(2, 1'b1);

    // same-cycle START/END of TEXE
    step(2'b11, 32'h0040_2013, 32'h0050_2013, 16'd7, 1'b0);
    chk("t2_active", 64'(phase_active[2]), 64'd0);
    idle(3, 1'b1);

    // orphan END, restart
    step(2'b01, 32'h0070_2013, '0, 16'd1, 1'b0);
    chk("t3_orphan", 64'(evt_data),
        64'(rec(cyc - 1, 3, 1, 1, 0, 0, 0)));
    step(2'b10, '0, 32'h0020_2013, 16'd2, 1'b1);
    idle(2, 1'b1);
    step(2'b01, 32'h0020_2013, '0, 16'd5, 1'b1);
    idle(2, 1'b1);
    step(2'b10, '0, 32'h0030_2013, 16'd6, 1'b1);
    idle(6, 1'b1);

    // overflow: 18 records into 16 slots
    for (int k = 0; k < 18; k++)
      step(2'b01, (k % 2 == 0) ? 32'h0080_2013 : 32'h0090_2013,
           '0, 16'(k), 1'b0);
    chk("t4_drops", 64'(drop_count), 64'd2);
    chk("t4_ovf", 64'(overflow), 64'd1);
    idle(18, 1'b1);
    chk("t4_empty", 64'(evt_valid), 64'd0);
    chk("t4_sticky", 64'(overflow), 64'd1);

    // random traffic
    for (int k = 0; k < 600; k++)
      step(2'($urandom), rnd_inst(), rnd_inst(),
           16'($urandom), $urandom_range(0, 3) != 0);
    idle(20, 1'b1);

    // counter saturation and ts wrap
    step(2'b01, 32'h00C0_2013, '0, 16'd1, 1'b1);
    idle(1030, 1'b1);
    step(2'b01, 32'h00D0_2013, '0, 16'd2, 1'b0);
    chk("t5_sat", 64'(evt_data[25:16]), 64'h3FF);
    idle(4, 1'b1);

    // async reset mid-phase with 5 queued records
    step(2'b11, 32'h0000_2013, 32'h0020_2013, 16'd3, 1'b0);
    step(2'b11, 32'h0040_2013, 32'h00B0_2013, 16'd3, 1'b0);
    step(2'b01, 32'h0090_2013, '0, 16'd3, 1'b0);
    chk("t6_active", 64'(phase_active[2:0]), 64'h7);
    #1;
    chk_en = 1'b0;
    reset = 1'b0;
    #1;
    zero_checks("t6_async");
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
    chk_en = 1'b1;
    step(2'b01, 32'h0000_2013, '0, 16'd8, 1'b0);
    chk("t6_ts0", 64'(evt_data), 64'(rec(0, 0, 0, 0, 0, 0, 8)));
    idle(4, 1'b1);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
